// File: rtl/rx_window_pkg.sv
// Shared types and default widths for the receive-window sequencer.
package rx_window_pkg;

    localparam int DEF_DLY_W = 16;
    localparam int DEF_CNT_W = 16;
    localparam int RATE_W    = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        DELAY  = 3'd2,
        WINDOW = 3'd3,
        DONE   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_load_counter.sv
// Loadable down-counter with a zero flag; stops at zero instead of wrapping.
module rx_load_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/rx_window_ctrl.sv
// Receive-window sequencer: trigger -> programmable delay -> N-strobe window -> re-arm.
// Define RX_WINDOW_OVERRUN_EN to build the sticky overrun detector for triggers arriving while busy.
module rx_window_ctrl
    import rx_window_pkg::*;
#(
    parameter int DLY_W = DEF_DLY_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              arm_i,
    input  logic              trigger_i,
    input  logic [DLY_W-1:0]  cfg_delay_i,
    input  logic [CNT_W-1:0]  cfg_nsamples_i,
    input  logic [RATE_W-1:0] cfg_rate_i,
    input  logic              strobe_i,
    output logic              gen_enable_o,
    output logic [RATE_W-1:0] gen_rate_o,
    output logic              window_active_o,
    output logic              window_done_o,
    output logic [CNT_W-1:0]  sample_count_o,
    output logic              overrun_o,
    output rx_state_e         state_o
);

    // Handshake: trigger_i is a single-cycle pulse honoured only in ARMED with arm_i high;
    // strobe_i is counted only in WINDOW; window_done_o is a one-cycle pulse.

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  ns_q, ns_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [RATE_W-1:0] rate_q, rate_d;

    logic              accept;
    logic              last_strobe;
    logic              dly_load;
    logic              dly_zero;
    logic [DLY_W-1:0]  dly_load_val;

    assign accept      = (state_q == ARMED) && arm_i && trigger_i;
    assign last_strobe = (state_q == WINDOW) && strobe_i && ((count_q + CNT_W'(1)) == ns_q);

    // Loading delay-1 lets the zero flag mark the final DELAY cycle.
    assign dly_load     = accept && (cfg_delay_i != '0);
    assign dly_load_val = cfg_delay_i - DLY_W'(1);

    rx_load_counter #(
        .W (DLY_W)
    ) u_delay_cnt (
        .clk_i      (clock_i),
        .rst_i      (reset_i),
        .load_i     (dly_load),
        .load_val_i (dly_load_val),
        .dec_i      (state_q == DELAY),
        .zero_o     (dly_zero)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!arm_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED: begin
                    if (trigger_i) begin
                        if (cfg_delay_i != '0) begin
                            state_d = DELAY;
                        end else if (cfg_nsamples_i == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = WINDOW;
                        end
                    end
                end
                DELAY: begin
                    if (dly_zero) begin
                        state_d = (ns_q == '0) ? DONE : WINDOW;
                    end
                end
                WINDOW: begin
                    if (last_strobe) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        gen_enable_o    = 1'b0;
        window_active_o = 1'b0;
        window_done_o   = 1'b0;
        case (state_q)
            WINDOW: begin
                gen_enable_o    = 1'b1;
                window_active_o = 1'b1;
            end
            DONE:    window_done_o = 1'b1;
            default: ;
        endcase
    end

    // Shadow configuration is captured only on the accepted trigger.
    always_comb begin
        ns_d    = ns_q;
        rate_d  = rate_q;
        count_d = count_q;
        if (accept) begin
            ns_d    = cfg_nsamples_i;
            rate_d  = cfg_rate_i;
            count_d = '0;
        end else if ((state_q == WINDOW) && arm_i && strobe_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ns_q    <= '0;
            rate_q  <= '0;
            count_q <= '0;
        end else begin
            ns_q    <= ns_d;
            rate_q  <= rate_d;
            count_q <= count_d;
        end
    end

    assign gen_rate_o     = rate_q;
    assign sample_count_o = count_q;
    assign state_o        = state_q;

`ifdef RX_WINDOW_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (!arm_i) begin
            ovr_d = 1'b0;
        end else if (trigger_i && ((state_q == DELAY) || (state_q == WINDOW) || (state_q == DONE))) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_o = ovr_q;
`else
    assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_rx_window_ctrl.sv
// Scoreboard bench for rx_window_ctrl: random windows with a per-window reference computed up front.
module tb_rx_window_ctrl;
    import rx_window_pkg::*;

`ifdef RX_WINDOW_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        trigger;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_nsamples;
    logic [7:0]  cfg_rate;
    logic        strobe;
    logic        gen_enable;
    logic [7:0]  gen_rate;
    logic        window_active;
    logic        window_done;
    logic [15:0] sample_count;
    logic        overrun;
    rx_state_e   state;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    bit exp_ovr = 1'b0;

    typedef struct packed {
        logic [31:0] open;
        logic [31:0] endc;
        logic [15:0] cnt;
        logic [7:0]  rate;
        logic        abort;
        logic        has_win;
    } exp_t;

    exp_t exp_q[$];

    rx_window_ctrl dut (
        .clock_i         (clk),
        .reset_i         (rst),
        .arm_i           (arm),
        .trigger_i       (trigger),
        .cfg_delay_i     (cfg_delay),
        .cfg_nsamples_i  (cfg_nsamples),
        .cfg_rate_i      (cfg_rate),
        .strobe_i        (strobe),
        .gen_enable_o    (gen_enable),
        .gen_rate_o      (gen_rate),
        .window_active_o (window_active),
        .window_done_o   (window_done),
        .sample_count_o  (sample_count),
        .overrun_o       (overrun),
        .state_o         (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            trigger = 1'b0;
            strobe  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic rearm();
        @(negedge clk);
        arm = 1'b0; trigger = 1'b0;
        @(negedge clk);
        arm = 1'b1;
        exp_ovr = 1'b0;
        @(negedge clk);
        chk("overrun_after_rearm", 32'(overrun), 32'(1'b0));
    endtask

    // Called at the negedge of the trigger cycle with the DUT in ARMED; returns at the
    // first cycle in which the next trigger may be accepted.
    task automatic run_window(input int d, input int n, input int r, input int abort_k, input bit extra);
        bit   sq[$];
        int   t, open, c, cnt, endc;
        bit   b, ab;
        exp_t e;
        t    = cyc;
        open = t + 1 + d;
        ab   = (abort_k > 0) && (n > abort_k);
        c    = t;
        cnt  = 0;
        endc = open;
        if (n > 0) begin
            while (1) begin
                b = ($urandom_range(0, 2) != 0);
                if (c >= open && ab && cnt == abort_k) begin
                    sq.push_back(1'b0);
                    endc = c + 1;
                    break;
                end
                sq.push_back(b);
                if (c >= open && b) begin
                    cnt++;
                    if (cnt == n) begin
                        endc = c + 1;
                        break;
                    end
                end
                c++;
            end
        end else begin
            for (int i = t; i < open; i++) sq.push_back(1'($urandom_range(0, 1)));
        end
        e.open    = 32'(open);
        e.endc    = 32'(endc);
        e.cnt     = ab ? 16'(abort_k) : 16'(n);
        e.rate    = 8'(r);
        e.abort   = ab;
        e.has_win = (n > 0);
        exp_q.push_back(e);

        for (int i = 0; i < sq.size(); i++) begin
            if (i > 0) @(negedge clk);
            strobe  = sq[i];
            trigger = (i == 0) || (extra && !ab && (i == 1 || $urandom_range(0, 3) == 0));
            if (i == 0) begin
                cfg_delay    = 16'(d);
                cfg_nsamples = 16'(n);
                cfg_rate     = 8'(r);
            end else begin
                cfg_delay    = 16'($urandom_range(0, 65535));
                cfg_nsamples = 16'($urandom_range(0, 65535));
                cfg_rate     = 8'($urandom_range(0, 255));
                if (trigger) exp_ovr = 1'b1;
            end
            if (ab && i == sq.size() - 1) arm = 1'b0;
        end
        @(negedge clk);
        strobe  = 1'($urandom_range(0, 1));
        trigger = extra && !ab && ($urandom_range(0, 1) == 0);
        if (trigger) exp_ovr = 1'b1;
        if (ab) exp_ovr = 1'b0;
        arm = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        chk("overrun", 32'(overrun), 32'(exp_ovr & OVR_EN));
    endtask

    // ---------------- scoreboard monitor ----------------
    bit prev_en = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        bit   have, ea, ed, ev;
        if (mon_en) begin
            have = (exp_q.size() > 0);
            e    = have ? exp_q[0] : '0;
            ea   = have && e.has_win && (cyc >= int'(e.open)) && (cyc < int'(e.endc));
            ed   = have && !e.abort && (cyc == int'(e.endc));
            chk("gen_enable", 32'(gen_enable), 32'(ea));
            chk("window_active", 32'(window_active), 32'(ea));
            chk("window_done", 32'(window_done), 32'(ed));
            ev = window_done || (prev_en && !gen_enable);
            if (ev) begin
                if (!have) begin
                    chk("unexpected_window_end", 32'(1), 32'(0));
                end else begin
                    chk("end_cycle", 32'(cyc), e.endc);
                    chk("sample_count", 32'(sample_count), 32'(e.cnt));
                    chk("gen_rate", 32'(gen_rate), 32'(e.rate));
                    void'(exp_q.pop_front());
                end
            end else if (have && cyc > int'(e.endc)) begin
                chk("window_end_timeout", 32'(cyc), e.endc);
                void'(exp_q.pop_front());
            end
            prev_en = gen_enable;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int d, n, r, k;
        rst = 1'b1; arm = 1'b0; trigger = 1'b0; strobe = 1'b0;
        cfg_delay = '0; cfg_nsamples = '0; cfg_rate = '0;
        repeat (3) @(negedge clk);
        chk("rst_gen_enable", 32'(gen_enable), 32'(0));
        chk("rst_gen_rate", 32'(gen_rate), 32'(0));
        chk("rst_window_active", 32'(window_active), 32'(0));
        chk("rst_window_done", 32'(window_done), 32'(0));
        chk("rst_sample_count", 32'(sample_count), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        chk("rst_state", 32'(state), 32'(IDLE));
        rst    = 1'b0;
        mon_en = 1'b1;
        arm    = 1'b1;
        @(negedge clk);

        run_window(5, 4, 3, 0, 1'b0);
        run_window(0, 1, 8'h21, 0, 1'b0);
        run_window(0, 1, 8'h22, 0, 1'b0);
        idle(2);
        run_window(2, 0, 8'h55, 0, 1'b0);
        run_window(1, 3, 3, 0, 1'b0);
        run_window(1, 2, 7, 0, 1'b0);
        run_window(1, 4, 5, 2, 1'b0);
        run_window(3, 2, 9, 0, 1'b1);
        rearm();

        for (int w = 0; w < 60; w++) begin
            d = $urandom_range(0, 8);
            n = $urandom_range(0, 6);
            r = $urandom_range(0, 255);
            k = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            run_window(d, n, r, k, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) rearm();
            else idle($urandom_range(0, 3));
        end

        idle(10);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_window_ctrl.md
# rx_window_ctrl

Receive-window sequencer for the sample-strobe generator. On each radar trigger (IPP) it waits a programmable delay, enables the strobe generator at a latched decimation rate, counts exactly N strobes, then closes the window and re-arms. It sits between the host-register block (config, arm) and the strobe generator / downstream sample packer (gen_enable, gen_rate, window_active).

## Interface
- DLY_W, 16, width of delay counter and cfg_delay
- CNT_W, 16, width of sample counter, cfg_nsamples and sample_count
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- arm  in  1  level; 1 = accept triggers, 0 = abort/idle
- trigger  in  1  single-cycle IPP pulse
- cfg_delay  in  DLY_W  clocks from trigger acceptance to window open
- cfg_nsamples  in  CNT_W  strobes per window
- cfg_rate  in  8  rate value forwarded to strobe generator
- strobe  in  1  strobe from strobe generator
- gen_enable  out  1  enable to strobe generator
- gen_rate  out  8  latched rate to strobe generator
- window_active  out  1  high while state is WINDOW
- window_done  out  1  one-cycle pulse at window close
- sample_count  out  CNT_W  strobes counted in current/last window
- overrun  out  1  sticky: trigger arrived while busy (see Configuration)

## Operation
- States: IDLE, ARMED, DELAY, WINDOW, DONE. Reset → IDLE.
- IDLE: arm=1 → ARMED next cycle.
- ARMED: trigger=1 → latch cfg_delay, cfg_nsamples, cfg_rate into shadow regs; clear sample_count; go DELAY (cfg_delay>0) or WINDOW (cfg_delay=0). If latched nsamples=0, go DONE instead of WINDOW.
- DELAY: down-count shadow delay once per clock; at 1 → WINDOW (or DONE if nsamples=0).
- WINDOW: gen_enable=1; each strobe=1 increments sample_count; strobe that makes sample_count equal shadow nsamples → DONE.
- DONE: one cycle; window_done=1; → ARMED if arm=1, else IDLE.
- arm=0 in any state → IDLE next cycle; gen_enable drops, no window_done, sample_count holds.
- cfg_* changes outside ARMED-trigger cycle have no effect on the current window.
- gen_rate always drives shadow rate; sample_count saturates never (bounded by nsamples).
- Reset values: gen_enable 0, gen_rate 0, window_active 0, window_done 0, sample_count 0, overrun 0.

## Timing
- Trigger accepted in cycle T → gen_enable/window_active high from T+1+cfg_delay.
- Strobe generator's first strobe appears one cycle after gen_enable rises; controller does not assume this, it only counts.
- Nth strobe sampled in cycle S → gen_enable, window_active low and window_done high at S+1; ARMED at S+2 (trigger accepted from S+2).
- nsamples=0: window_done at T+1+cfg_delay, gen_enable never asserted.
- All outputs registered; no combinational input→output paths.

## Configuration
- RX_WINDOW_OVERRUN_EN defined: trigger=1 in DELAY, WINDOW or DONE sets overrun; cleared only by reset or arm=0. Trigger is otherwise ignored.
- Not defined: such triggers silently ignored; overrun tied 0; detection logic absent.

## Structure
- Package rx_window_pkg: state enum (IDLE, ARMED, DELAY, WINDOW, DONE), default widths DLY_W/CNT_W, rate width constant 8.
- One sub-module: rx_load_counter — loadable down-counter with zero flag, instantiated for the delay count; sample counter is an up-counter inline.

## Test plan
- arm=1, cfg_delay=5, nsamples=4, rate=3, trigger at T → gen_enable rises T+6, gen_rate=3, window_done one cycle after 4th strobe, sample_count=4.
- cfg_delay=0, nsamples=1 → gen_enable at T+1, closes after first strobe; re-trigger accepted two cycles after that strobe.
- nsamples=0, delay=2 → window_done at T+3, gen_enable never high, sample_count=0.
- Change cfg_rate 3→7 mid-window → gen_rate stays 3; next trigger latches 7.
- arm dropped mid-WINDOW after 2 strobes → IDLE next cycle, gen_enable 0, no window_done, sample_count=2.
- Macro on: trigger during DELAY → overrun=1, window unaffected; arm=0 clears overrun. Macro off: same stimulus → overrun stays 0.
